// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: shared definitions for the SPI slave / RAM pair.
//   - CMD_* : 2-bit opcodes carried in din[9:8]. The SPI slave uses the same
//             constants to decide how many bits to shift and when to turn
//             MISO around for a read.
//   - state_e : RAM-side read-handshake states.
//   - f_cmd / f_payload : split a 10-bit word into opcode and payload.
package spi_ram_pkg;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RD_WAIT = 2'b01,
    RD_HOLD = 2'b10
  } state_e;

  function automatic logic [1:0] f_cmd(input logic [9:0] word);
    return word[9:8];
  endfunction

  function automatic logic [7:0] f_payload(input logic [9:0] word);
    return word[7:0];
  endfunction

endpackage

// File: rtl/spi_ram_spram_core.sv
// spram_core: plain synchronous single-port 8-bit RAM, no reset on contents.
//   clk      : clock, rising edge
//   i_we     : write enable (wins over i_re)
//   i_re     : read enable; o_rdata updates one edge later, otherwise holds
//   i_addr   : word address, must be < DEPTH whenever i_we/i_re is high
//   i_wdata  : write data
//   o_rdata  : registered read data
module spram_core #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic          i_re,
  input  logic [AW-1:0] i_addr,
  input  logic [7:0]    i_wdata,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [0:DEPTH-1];
  logic [7:0] r_rdata;

  // Storage write port and registered read port sharing one address.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end else begin
      r_rdata <= r_rdata;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/spi_ram.sv
// spi_ram: command-decoding RAM sitting behind the SPI slave.
//   clk      : system clock, rising edge
//   rst      : synchronous active-high reset
//   din      : [9:8] opcode, [7:0] address/data payload (SPI rx_data)
//   rx_valid : din-valid level; only its rising edge accepts a command
//   dout     : read data back to the SPI slave (tx_data)
//   tx_valid : dout valid; high from read completion until the next command
module spi_ram
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] din,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       tx_valid
);

  // Depth widened by one bit so MEM_DEPTH == 2**ADDR_SIZE still compares.
  localparam logic [ADDR_SIZE:0] LP_DEPTH = (ADDR_SIZE + 1)'(MEM_DEPTH);

  state_e               r_state;
  state_e               w_state_next;
  logic                 r_rx_valid_q;
  logic [ADDR_SIZE-1:0] r_wr_addr;
  logic [ADDR_SIZE-1:0] r_rd_addr;
  logic                 r_rd_oob;
  logic [7:0]           r_dout;
  logic                 r_tx_valid;

  logic                 w_accept;
  logic [1:0]           w_cmd;
  logic [7:0]           w_payload;
  logic                 w_wr_oob;
  logic                 w_rd_oob;
  logic                 w_mem_we;
  logic                 w_mem_re;
  logic [ADDR_SIZE-1:0] w_mem_addr;
  logic [7:0]           w_mem_rdata;
  logic                 w_ld_dout;
  logic                 w_tx_next;

  assign w_accept  = rx_valid & ~r_rx_valid_q;
  assign w_cmd     = f_cmd(din);
  assign w_payload = f_payload(din);
  assign w_wr_oob  = ({1'b0, r_wr_addr} >= LP_DEPTH);
  assign w_rd_oob  = ({1'b0, r_rd_addr} >= LP_DEPTH);

  spram_core #(
    .DEPTH (MEM_DEPTH),
    .AW    (ADDR_SIZE)
  ) u_core (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_re    (w_mem_re),
    .i_addr  (w_mem_addr),
    .i_wdata (w_payload),
    .o_rdata (w_mem_rdata)
  );

  // RAM port control: out-of-range addresses never reach the array.
  always_comb begin
    w_mem_we   = 1'b0;
    w_mem_re   = 1'b0;
    w_mem_addr = r_rd_addr;
    if (w_accept) begin
      case (w_cmd)
        CMD_WR_DATA: begin
          w_mem_we   = ~w_wr_oob;
          w_mem_addr = r_wr_addr;
        end
        CMD_RD_DATA: begin
          w_mem_re   = ~w_rd_oob;
          w_mem_addr = r_rd_addr;
        end
        default: begin
          w_mem_we = 1'b0;
          w_mem_re = 1'b0;
        end
      endcase
    end else begin
      w_mem_we = 1'b0;
      w_mem_re = 1'b0;
    end
  end

  // Read-handshake FSM next state and output intent.
  always_comb begin
    w_state_next = r_state;
    w_ld_dout    = 1'b0;
    w_tx_next    = r_tx_valid;
    case (r_state)
      IDLE: begin
        w_tx_next = 1'b0;
        if (w_accept && (w_cmd == CMD_RD_DATA)) begin
          w_state_next = RD_WAIT;
        end else begin
          w_state_next = IDLE;
        end
      end
      RD_WAIT: begin
        // Array data launched on the accepting edge is ready now; a command
        // landing here still runs, and a fresh read restarts the wait.
        w_ld_dout = 1'b1;
        w_tx_next = 1'b1;
        if (w_accept && (w_cmd == CMD_RD_DATA)) begin
          w_state_next = RD_WAIT;
        end else begin
          w_state_next = RD_HOLD;
        end
      end
      RD_HOLD: begin
        if (w_accept) begin
          w_tx_next = 1'b0;
          if (w_cmd == CMD_RD_DATA) begin
            w_state_next = RD_WAIT;
          end else begin
            w_state_next = IDLE;
          end
        end else begin
          w_tx_next    = 1'b1;
          w_state_next = RD_HOLD;
        end
      end
      default: begin
        w_tx_next    = 1'b0;
        w_state_next = IDLE;
      end
    endcase
  end

  // State, address registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_rx_valid_q <= 1'b1;
      r_wr_addr    <= '0;
      r_rd_addr    <= '0;
      r_rd_oob     <= 1'b0;
      r_dout       <= 8'h00;
      r_tx_valid   <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_rx_valid_q <= rx_valid;
      r_tx_valid   <= w_tx_next;
      if (w_accept && (w_cmd == CMD_WR_ADDR)) begin
        r_wr_addr <= ADDR_SIZE'(w_payload);
      end else begin
        r_wr_addr <= r_wr_addr;
      end
      if (w_accept && (w_cmd == CMD_RD_ADDR)) begin
        r_rd_addr <= ADDR_SIZE'(w_payload);
      end else begin
        r_rd_addr <= r_rd_addr;
      end
      // Range is judged at launch so a later RD_ADDR cannot change the result.
      if (w_accept && (w_cmd == CMD_RD_DATA)) begin
        r_rd_oob <= w_rd_oob;
      end else begin
        r_rd_oob <= r_rd_oob;
      end
      if (w_ld_dout) begin
        r_dout <= r_rd_oob ? 8'h00 : w_mem_rdata;
      end else begin
        r_dout <= r_dout;
      end
    end
  end

  assign dout     = r_dout;
  assign tx_valid = r_tx_valid;

endmodule

// File: tb/tb_spi_ram.sv
// tb_spi_ram: directed, scoreboard-based bench for spi_ram (MEM_DEPTH=200).
module tb_spi_ram;

  logic       clk;
  logic       rst;
  logic [9:0] din;
  logic       rx_valid;
  logic [7:0] dout;
  logic       tx_valid;

  int n_pass;
  int n_total;
  logic [7:0] sb[$];

  spi_ram #(
    .MEM_DEPTH (200),
    .ADDR_SIZE (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .rx_valid (rx_valid),
    .dout     (dout),
    .tx_valid (tx_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
  endtask

  // One command: rx_valid high for 'hold' cycles, then low for one cycle.
  task automatic send(input logic [9:0] d, input int hold);
    din      = d;
    rx_valid = 1'b1;
    repeat (hold) tick();
    rx_valid = 1'b0;
    tick();
  endtask

  // RD_DATA with expected result queued; checks 2-cycle latency and hold.
  task automatic rd(input string name, input logic [7:0] exp);
    logic [7:0] e;
    sb.push_back(exp);
    din      = 10'h300;
    rx_valid = 1'b1;
    tick();
    chk({name, "_lat1"}, 32'(tx_valid), 32'd0);
    rx_valid = 1'b0;
    tick();
    chk({name, "_valid"}, 32'(tx_valid), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({name, "_data"}, 32'(dout), 32'(e));
      tick();
      chk({name, "_hold_v"}, 32'(tx_valid), 32'd1);
      chk({name, "_hold_d"}, 32'(dout), 32'(e));
    end else begin
      chk({name, "_sb_empty"}, 32'd0, 32'd1);
    end
  endtask

  initial begin
    n_pass   = 0;
    n_total  = 0;
    rst      = 1'b1;
    din      = 10'h0AA;
    rx_valid = 1'b1;
    repeat (3) tick();
    chk("rst_tx", 32'(tx_valid), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);

    // Release with rx_valid already high: must be ignored.
    rst = 1'b0;
    repeat (3) tick();
    chk("rel_tx", 32'(tx_valid), 32'd0);
    chk("rel_dout", 32'(dout), 32'd0);
    rx_valid = 1'b0;
    tick();
    // wr_addr must still be 0, so this lands at address 0.
    send(10'h177, 1);
    send(10'h200, 1);
    rd("rel_ignored", 8'h77);

    // Basic write/read round trip.
    send(10'h012, 1);
    send(10'h15A, 1);
    send(10'h212, 1);
    rd("basic", 8'h5A);

    // In RD_HOLD: WR_ADDR clears tx_valid at decode, dout untouched.
    din      = 10'h020;
    rx_valid = 1'b1;
    tick();
    chk("hold_cmd_tx", 32'(tx_valid), 32'd0);
    chk("hold_cmd_dout", 32'(dout), 32'h5A);
    rx_valid = 1'b0;
    tick();
    chk("hold_cmd_dout2", 32'(dout), 32'h5A);
    send(10'h1C3, 1);
    send(10'h220, 1);
    rd("hold_wraddr", 8'hC3);

    // Long rx_valid: only the rising edge writes; later din change ignored.
    send(10'h003, 1);
    din      = 10'h1FF;
    rx_valid = 1'b1;
    repeat (6) tick();
    din = 10'h111;
    repeat (6) tick();
    rx_valid = 1'b0;
    tick();
    send(10'h203, 4);
    rd("long_valid", 8'hFF);

    // Boundary: last valid address, then first out-of-range address.
    send(10'h0C7, 1);
    send(10'h15C, 1);
    send(10'h2C7, 1);
    rd("last_addr", 8'h5C);
    send(10'h0C8, 1);
    send(10'h1AB, 1);
    send(10'h2C8, 1);
    rd("oob", 8'h00);
    send(10'h2C7, 1);
    rd("oob_no_alias", 8'h5C);

    // Reset while in RD_WAIT.
    send(10'h203, 1);
    din      = 10'h300;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rst      = 1'b1;
    tick();
    chk("rst_rdwait_tx", 32'(tx_valid), 32'd0);
    chk("rst_rdwait_dout", 32'(dout), 32'd0);
    rst = 1'b0;
    repeat (2) tick();
    chk("rst_rdwait_idle_tx", 32'(tx_valid), 32'd0);
    send(10'h203, 1);
    rd("mem_after_rst", 8'hFF);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
